// File: rtl/word_unpacker.sv
// ---------------------------------------------------------------------------
// word_unpacker
//   Buffers 24-bit words in a small FIFO and presents each one downstream as
//   three bytes, most significant byte first, using a valid/ready handshake.
//   The producer side has no backpressure: a word strobed while the buffer is
//   full (and nothing pops that cycle) is dropped and sets a sticky overflow.
//
// Parameters
//   DEPTH   : word buffer depth, power of two, >= 2
//
// Ports
//   clk     : clock, all state updates on the rising edge
//   clr_n   : asynchronous active-low reset
//   in      : 24-bit word, sampled only when ena_in=1
//   ena_in  : single-cycle strobe qualifying in
//   rdy_in  : downstream ready; byte transfers when ena_out & rdy_in
//   out     : current byte (8'h00 when ena_out=0)
//   ena_out : out valid
//   full    : buffer holds DEPTH words
//   level   : words buffered, including the word being unpacked
//   ovf     : sticky overflow, cleared only by reset
// ---------------------------------------------------------------------------
module word_unpacker #(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic          clk,
  input  logic          clr_n,
  input  logic [23:0]   in,
  input  logic          ena_in,
  input  logic          rdy_in,
  output logic [7:0]    out,
  output logic          ena_out,
  output logic          full,
  output logic [LW-1:0] level,
  output logic          ovf
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_B0   = 2'd1,
    S_B1   = 2'd2,
    S_B2   = 2'd3
  } state_e;

  logic [23:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] level_q, level_d;
  state_e        state_q;
  logic          ena_out_q;
  logic          ovf_q;

  logic xfer, pop, push, drop;
  logic [23:0] head;

  assign full = (level_q == LW'(DEPTH));
  assign xfer = ena_out_q & rdy_in;
  // The head word leaves the buffer when its last byte is taken.
  assign pop  = xfer & (state_q == S_B2);
  // A full buffer can still accept a word if the head pops in the same cycle.
  assign push = ena_in & (~full | pop);
  assign drop = ena_in & full & ~pop;
  assign head = mem[rd_ptr_q];

  // NOTE: combinational blocks assign a default first so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // NOTE: the word storage has no reset; the pointers and level define which
  // entries are meaningful, so stale contents after reset are never read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= in;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      // Pointers are AW bits wide, so increments wrap modulo DEPTH.
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q <= level_d;
      if (drop) ovf_q <= 1'b1;
    end
  end

  // Byte-index FSM; ena_out is registered alongside the state it decodes.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q   <= S_IDLE;
      ena_out_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (level_q != '0) begin
            state_q   <= S_B0;
            ena_out_q <= 1'b1;
          end
        end
        S_B0: if (xfer) state_q <= S_B1;
        S_B1: if (xfer) state_q <= S_B2;
        S_B2: begin
          if (xfer) begin
            // Go straight to the next word's MSB when one is waiting, so
            // consecutive words stream without a gap.
            if (level_d != '0) begin
              state_q <= S_B0;
            end else begin
              state_q   <= S_IDLE;
              ena_out_q <= 1'b0;
            end
          end
        end
        default: begin
          state_q   <= S_IDLE;
          ena_out_q <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    out = 8'h00;
    case (state_q)
      S_B0:    out = head[23:16];
      S_B1:    out = head[15:8];
      S_B2:    out = head[7:0];
      default: out = 8'h00;
    endcase
  end

  assign ena_out = ena_out_q;
  assign level   = level_q;
  assign ovf     = ovf_q;

endmodule

// File: doc/word_unpacker.md
WORD_UNPACKER -- requirements
Module: word_unpacker

Interface
REQ-001 Parameter DEPTH, default 4: word buffer depth; SHALL be a power of two, minimum 2.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 clr_n  input  1  asynchronous, active-low reset.
REQ-004 in  input  24  word to be unpacked; sampled only when ena_in=1.
REQ-005 ena_in  input  1  single-cycle strobe marking in valid; no backpressure toward the producer.
REQ-006 rdy_in  input  1  downstream ready; a byte transfers on a cycle with ena_out=1 and rdy_in=1.
REQ-007 out  output  8  current byte presented downstream.
REQ-008 ena_out  output  1  out valid.
REQ-009 full  output  1  buffer holds DEPTH words.
REQ-010 level  output  log2(DEPTH)+1  number of words buffered, including the word being unpacked.
REQ-011 ovf  output  1  sticky overflow flag.

Function
REQ-012 Write: ena_in=1 and full=0 -> in stored at tail and level+1 at the next edge.
REQ-013 Write while full: ena_in=1, full=1 and no pop that cycle -> word dropped, contents unchanged, ovf=1 from the next edge.
REQ-014 Write while full with pop the same cycle -> word accepted; level unchanged; ovf unchanged.
REQ-015 Byte order SHALL be MSB first: head[23:16], then head[15:8], then head[7:0].
REQ-016 Byte-index FSM states: IDLE (level=0), B0, B1, B2. out selects the head byte for the current state.
REQ-017 IDLE -> B0 on the edge after level becomes nonzero.
REQ-018 B0 -> B1 and B1 -> B2 on each transfer.
REQ-019 A transfer in B2 pops the head word; the next state is B0 if level after the pop is nonzero, otherwise IDLE.
REQ-020 No transfer (rdy_in=0) -> state, out and ena_out held stable.
REQ-021 ena_out SHALL be 1 exactly in B0, B1 and B2.
REQ-022 out SHALL be 8'h00 whenever ena_out=0.
REQ-023 Latency into an empty buffer: a word strobed at edge k gives ena_out=1 with byte [23:16] in the cycle after edge k+1.
REQ-024 With rdy_in held at 1, bytes SHALL stream back-to-back with no idle cycle between consecutive words.
REQ-025 Sustained throughput SHALL be one word per 3 cycles.
REQ-026 Pointers wrap modulo DEPTH.
REQ-027 full = (level==DEPTH).
REQ-028 Simultaneous write and pop when not full -> level unchanged.
REQ-029 rdy_in is ignored when ena_out=0.
REQ-030 in is ignored when ena_in=0.

Reset
REQ-031 clr_n=0 SHALL immediately, without a clock edge, force: state IDLE, pointers 0, level 0, full 0, ovf 0, ena_out 0, out 8'h00.
REQ-032 Reset mid-word SHALL discard all buffered words and any partially sent word.
REQ-033 After clr_n deasserts, the first word is accepted on the first rising edge with ena_in=1.
REQ-034 ovf SHALL clear only on reset.

Verification
REQ-035 Single word, rdy_in=1: strobe in=24'hA1B2C3 -> out A1, B2, C3 on three consecutive cycles with ena_out=1; then ena_out=0, out=00, level=0.
REQ-036 Backpressure: same word, rdy_in=0 for 5 cycles, then 1 -> out held at A1 with ena_out=1 for all 5 cycles; A1, B2, C3 follow after release.
REQ-037 Overflow, DEPTH=4, rdy_in=0: strobe 5 words 24'h000001 to 24'h000005 -> full=1, level=4, ovf=1; on release, output 00 00 01 ... 00 00 04 and word 5 absent.
REQ-038 Full with pop, DEPTH=4: 4 words buffered; in B2 with rdy_in=1, strobe 24'h123456 the same cycle -> word accepted, level stays 4, ovf=0; 12 34 56 appears last.
REQ-039 Async reset mid-word: clr_n pulsed low between clock edges while in B1 -> ena_out=0, out=00, level=0, ovf=0 before the next edge; the next strobed word streams from its MSB byte.
REQ-040 Streaming, rdy_in=1: strobe a word every 3 cycles for 10 words -> 30 contiguous ena_out cycles, level never exceeds 2, ovf=0.
